// File: rtl/ctrl_pkg.sv
// Shared control-path definitions for the decode stage and its pipeline
// registers: opcodes, select encodings and the E-stage control bundle.
package ctrl_pkg;

    // RV32I major opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Immediate format selects
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Writeback result selects
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // ALU decode classes handed from main decode to alu_ctrl_dec
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNC   = 2'b10;

    // E-stage control bundle; the hazard unit reuses this layout
    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alusrc;
        logic       alusrca;
        logic       illegal;
        logic [1:0] resultsrc;
        logic [3:0] aluctrl;
        logic [2:0] brtype;
    } ctrl_e_t;

    // Controls still needed after the execute stage
    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
    } ctrl_m_t;

    // Controls still needed in writeback
    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
    } ctrl_w_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU decode: maps the ALU class chosen by main decode plus funct3,
// funct7[5] and op[5] to a concrete ALU operation code.
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] aluctrl
);

    // Purely combinational class/funct3 lookup
    always_comb begin
        aluctrl = ALU_ADD;
        case (alu_op)
            ALUOP_BRANCH: begin
                // beq/bne compare by subtraction, blt/bge signed, bltu/bgeu unsigned
                case (funct3[2:1])
                    2'b00:   aluctrl = ALU_SUB;
                    2'b10:   aluctrl = ALU_SLT;
                    2'b11:   aluctrl = ALU_SLTU;
                    default: aluctrl = ALU_ADD;
                endcase
            end
            ALUOP_FUNC: begin
                case (funct3)
                    // only R-type (op[5]=1) can encode sub; addi ignores bit 30
                    3'b000:  aluctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  aluctrl = ALU_SLL;
                    3'b010:  aluctrl = ALU_SLT;
                    3'b011:  aluctrl = ALU_SLTU;
                    3'b100:  aluctrl = ALU_XOR;
                    // bit 30 selects arithmetic shift for both sra and srai
                    3'b101:  aluctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  aluctrl = ALU_OR;
                    default: aluctrl = ALU_AND;
                endcase
            end
            default: aluctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Decode-stage control unit: main + ALU decode, illegal-opcode detection,
// and the ID/EX, EX/MEM, MEM/WB control registers with stall/flush.
// Pipeline control semantics: FLUSH_E loads a bubble into E and wins over
// STALL_E; STALL_E alone holds E and sends a bubble to M so the held
// instruction retires once; M and W advance every cycle.
module ctrl_pipe_decoder
    import ctrl_pkg::*;
#(
    parameter bit EXT_EN    = 1'b1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          INSTR_D,
    input  logic                 STALL_E,
    input  logic                 FLUSH_E,
    output logic [2:0]           IMMSRC_D,
    output logic                 REGWRITE_E,
    output logic                 MEMWRITE_E,
    output logic                 BRANCH_E,
    output logic                 JUMP_E,
    output logic                 JALR_E,
    output logic                 ALUSRC_E,
    output logic                 ALUSRCA_E,
    output logic                 ILLEGAL_E,
    output logic [1:0]           RESULTSRC_E,
    output logic [3:0]           ALUCTRL_E,
    output logic [2:0]           BRTYPE_E,
    output logic                 REGWRITE_M,
    output logic                 MEMWRITE_M,
    output logic [1:0]           RESULTSRC_M,
    output logic                 REGWRITE_W,
    output logic [1:0]           RESULTSRC_W,
    output logic [ILL_CNT_W-1:0] ILL_CNT
);

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr_bits;

    assign op       = INSTR_D[6:0];
    assign funct3   = INSTR_D[14:12];
    assign funct7b5 = INSTR_D[30];
    // register specifiers and immediates are decoded elsewhere
    assign unused_instr_bits = ^{INSTR_D[31], INSTR_D[29:15], INSTR_D[11:7]};

    ctrl_e_t    ctrl_d;
    logic [2:0] imm_d;
    logic [1:0] alu_op;
    logic [3:0] aluctrl_d;
    logic       ill_d;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .op5      (op[5]),
        .aluctrl  (aluctrl_d)
    );

    // Main decode; an illegal word collapses to an all-zero bundle with ILLEGAL set
    always_comb begin
        ctrl_d = '0;
        imm_d  = IMM_I;
        alu_op = ALUOP_ADD;
        ill_d  = 1'b0;
        case (op)
            OP_LOAD: begin
                imm_d            = IMM_I;
                ctrl_d.alusrc    = 1'b1;
                ctrl_d.resultsrc = RES_MEM;
                ctrl_d.regwrite  = 1'b1;
            end
            OP_STORE: begin
                imm_d           = IMM_S;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            OP_RTYPE: begin
                ctrl_d.regwrite = 1'b1;
                alu_op          = ALUOP_FUNC;
            end
            OP_ITYPE: begin
                imm_d           = IMM_I;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                alu_op          = ALUOP_FUNC;
            end
            OP_BRANCH: begin
                imm_d         = IMM_B;
                ctrl_d.branch = 1'b1;
                ctrl_d.brtype = funct3;
                alu_op        = ALUOP_BRANCH;
                // funct3 01x has no branch encoding; reduced set keeps only beq
                if (funct3[2:1] == 2'b01)
                    ill_d = 1'b1;
                if (!EXT_EN && funct3 != 3'b000)
                    ill_d = 1'b1;
            end
            OP_JAL: begin
                imm_d            = IMM_J;
                ctrl_d.jump      = 1'b1;
                ctrl_d.resultsrc = RES_PC4;
                ctrl_d.regwrite  = 1'b1;
            end
            OP_JALR: begin
                if (EXT_EN) begin
                    imm_d            = IMM_I;
                    ctrl_d.alusrc    = 1'b1;
                    ctrl_d.jump      = 1'b1;
                    ctrl_d.jalr      = 1'b1;
                    ctrl_d.resultsrc = RES_PC4;
                    ctrl_d.regwrite  = 1'b1;
                end else begin
                    ill_d = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_EN) begin
                    imm_d            = IMM_U;
                    ctrl_d.resultsrc = RES_IMM;
                    ctrl_d.regwrite  = 1'b1;
                end else begin
                    ill_d = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (EXT_EN) begin
                    imm_d           = IMM_U;
                    ctrl_d.alusrca  = 1'b1;
                    ctrl_d.alusrc   = 1'b1;
                    ctrl_d.regwrite = 1'b1;
                end else begin
                    ill_d = 1'b1;
                end
            end
            default: ill_d = 1'b1;
        endcase

        if (ill_d) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
            imm_d          = IMM_I;
        end else begin
            ctrl_d.aluctrl = aluctrl_d;
        end
    end

    assign IMMSRC_D = imm_d;

    ctrl_e_t              e_q;
    ctrl_m_t              m_q;
    ctrl_w_t              w_q;
    logic [ILL_CNT_W-1:0] cnt_q;
    logic                 load_e;

    assign load_e = !FLUSH_E && !STALL_E;

    // ID/EX register: reset > flush > stall > load
    always_ff @(posedge CLK) begin
        if (RST)
            e_q <= '0;
        else if (FLUSH_E)
            e_q <= '0;
        else if (!STALL_E)
            e_q <= ctrl_d;
    end

    // EX/MEM register: a stalled E sends a bubble so it retires only once
    always_ff @(posedge CLK) begin
        if (RST)
            m_q <= '0;
        else if (STALL_E && !FLUSH_E)
            m_q <= '0;
        else
            m_q <= '{regwrite: e_q.regwrite, memwrite: e_q.memwrite,
                     resultsrc: e_q.resultsrc};
    end

    // MEM/WB register: advances every cycle
    always_ff @(posedge CLK) begin
        if (RST)
            w_q <= '0;
        else
            w_q <= '{regwrite: m_q.regwrite, resultsrc: m_q.resultsrc};
    end

    // Saturating count of illegal words actually accepted into E
    always_ff @(posedge CLK) begin
        if (RST)
            cnt_q <= '0;
        else if (load_e && ctrl_d.illegal && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign REGWRITE_E  = e_q.regwrite;
    assign MEMWRITE_E  = e_q.memwrite;
    assign BRANCH_E    = e_q.branch;
    assign JUMP_E      = e_q.jump;
    assign JALR_E      = e_q.jalr;
    assign ALUSRC_E    = e_q.alusrc;
    assign ALUSRCA_E   = e_q.alusrca;
    assign ILLEGAL_E   = e_q.illegal;
    assign RESULTSRC_E = e_q.resultsrc;
    assign ALUCTRL_E   = e_q.aluctrl;
    assign BRTYPE_E    = e_q.brtype;
    assign REGWRITE_M  = m_q.regwrite;
    assign MEMWRITE_M  = m_q.memwrite;
    assign RESULTSRC_M = m_q.resultsrc;
    assign REGWRITE_W  = w_q.regwrite;
    assign RESULTSRC_W = w_q.resultsrc;
    assign ILL_CNT     = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: directed instruction words, expected
// responses queued by the driver and checked by a separate monitor.
// Two instances: full RV32I subset (EXT_EN=1) and reduced set (EXT_EN=0),
// fed the same stimulus.
module tb_ctrl_pipe_decoder;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0000_0013;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (EXT_EN=1) ----------------
    logic [2:0] immsrc_d, brtype_e;
    logic       rw_e, mw_e, br_e, j_e, jr_e, as_e, asa_e, ill_e;
    logic [1:0] rs_e, rs_m, rs_w;
    logic [3:0] alu_e;
    logic       rw_m, mw_m, rw_w;
    logic [7:0] ill_cnt;

    ctrl_pipe_decoder #(.EXT_EN(1'b1), .ILL_CNT_W(8)) dut (
        .CLK(clk), .RST(rst), .INSTR_D(instr), .STALL_E(stall), .FLUSH_E(flush),
        .IMMSRC_D(immsrc_d),
        .REGWRITE_E(rw_e), .MEMWRITE_E(mw_e), .BRANCH_E(br_e), .JUMP_E(j_e),
        .JALR_E(jr_e), .ALUSRC_E(as_e), .ALUSRCA_E(asa_e), .ILLEGAL_E(ill_e),
        .RESULTSRC_E(rs_e), .ALUCTRL_E(alu_e), .BRTYPE_E(brtype_e),
        .REGWRITE_M(rw_m), .MEMWRITE_M(mw_m), .RESULTSRC_M(rs_m),
        .REGWRITE_W(rw_w), .RESULTSRC_W(rs_w), .ILL_CNT(ill_cnt)
    );

    // ---------------- DUT (EXT_EN=0) ----------------
    logic [2:0] immsrc_d0, brtype_e0;
    logic       rw_e0, mw_e0, br_e0, j_e0, jr_e0, as_e0, asa_e0, ill_e0;
    logic [1:0] rs_e0, rs_m0, rs_w0;
    logic [3:0] alu_e0;
    logic       rw_m0, mw_m0, rw_w0;
    logic [7:0] ill_cnt0;

    ctrl_pipe_decoder #(.EXT_EN(1'b0), .ILL_CNT_W(8)) dut0 (
        .CLK(clk), .RST(rst), .INSTR_D(instr), .STALL_E(stall), .FLUSH_E(flush),
        .IMMSRC_D(immsrc_d0),
        .REGWRITE_E(rw_e0), .MEMWRITE_E(mw_e0), .BRANCH_E(br_e0), .JUMP_E(j_e0),
        .JALR_E(jr_e0), .ALUSRC_E(as_e0), .ALUSRCA_E(asa_e0), .ILLEGAL_E(ill_e0),
        .RESULTSRC_E(rs_e0), .ALUCTRL_E(alu_e0), .BRTYPE_E(brtype_e0),
        .REGWRITE_M(rw_m0), .MEMWRITE_M(mw_m0), .RESULTSRC_M(rs_m0),
        .REGWRITE_W(rw_w0), .RESULTSRC_W(rs_w0), .ILL_CNT(ill_cnt0)
    );

    // E bundle order: rw mw br j jr as asa ill | rs[1:0] | alu[3:0] | bt[2:0]
    logic [16:0] ebus, ebus0;
    assign ebus  = {rw_e, mw_e, br_e, j_e, jr_e, as_e, asa_e, ill_e, rs_e, alu_e, brtype_e};
    assign ebus0 = {rw_e0, mw_e0, br_e0, j_e0, jr_e0, as_e0, asa_e0, ill_e0, rs_e0, alu_e0, brtype_e0};

    // ---------------- scoreboard ----------------
    localparam int S_IMM  = 0;
    localparam int S_E    = 1;
    localparam int S_M    = 2;   // {rw, mw, rs[1:0]}
    localparam int S_W    = 3;   // {rw, rs[1:0]}
    localparam int S_CNT  = 4;
    localparam int S_IMM0 = 5;
    localparam int S_E0   = 6;
    localparam int S_M0   = 7;
    localparam int S_W0   = 8;
    localparam int S_CNT0 = 9;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_IMM:   return {29'b0, immsrc_d};
            S_E:     return {15'b0, ebus};
            S_M:     return {28'b0, rw_m, mw_m, rs_m};
            S_W:     return {29'b0, rw_w, rs_w};
            S_CNT:   return {24'b0, ill_cnt};
            S_IMM0:  return {29'b0, immsrc_d0};
            S_E0:    return {15'b0, ebus0};
            S_M0:    return {28'b0, rw_m0, mw_m0, rs_m0};
            S_W0:    return {29'b0, rw_w0, rs_w0};
            default: return {24'b0, ill_cnt0};
        endcase
    endfunction

    function automatic logic [31:0] eb(input logic rw, mw, br, j, jr, as_, asa, ill,
                                       input logic [1:0] rs, input logic [3:0] alu,
                                       input logic [2:0] bt);
        return {15'b0, rw, mw, br, j, jr, as_, asa, ill, rs, alu, bt};
    endfunction

    task automatic push(input int at, input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.at = at; e.sig = sig; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: at each falling edge, compare every entry due this cycle
    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].at == cyc) begin
                    n_checks++;
                    act = actual(exp_q[i].sig);
                    if (act !== exp_q[i].val) begin
                        n_fail++;
                        $display("FAIL %s (cycle %0d): got %h, expected %h",
                                 exp_q[i].name, cyc, act, exp_q[i].val);
                    end
                    exp_q.delete(i);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] w, input logic st, input logic fl,
                         input logic r, output int c);
        @(negedge clk);
        #2;
        instr = w; stall = st; flush = fl; rst = r;
        c = cyc;
    endtask

    // Issue one word with no stall/flush and expect its E bundle and immediate select
    task automatic dec(input logic [31:0] w, input string name,
                       input logic [31:0] e_exp, input logic [2:0] imm_exp);
        int c;
        drive(w, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_E, e_exp, {name, "_E"});
        push(c + 1, S_IMM, {29'b0, imm_exp}, {name, "_IMM"});
    endtask

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LW    = 32'h0040_2283;
    localparam logic [31:0] SUB   = 32'h4020_81B3;
    localparam logic [31:0] SRAI  = 32'h4010_D093;
    localparam logic [31:0] SRLI  = 32'h0010_D093;
    localparam logic [31:0] XORI  = 32'h0040_C093;
    localparam logic [31:0] AND_R = 32'h0020_F1B3;
    localparam logic [31:0] OR_R  = 32'h0020_E1B3;
    localparam logic [31:0] LUI   = 32'h1234_50B7;
    localparam logic [31:0] AUIPC = 32'h0000_1097;
    localparam logic [31:0] JALR  = 32'h0001_00E7;
    localparam logic [31:0] JAL   = 32'h0000_00EF;
    localparam logic [31:0] BEQ   = 32'h0020_8063;
    localparam logic [31:0] BNE   = 32'h0020_9063;
    localparam logic [31:0] BLT   = 32'h0020_C063;
    localparam logic [31:0] BGEU  = 32'h0020_F063;
    localparam logic [31:0] BBAD  = 32'h0020_A063;
    localparam logic [31:0] SW    = 32'h0050_A423;
    localparam logic [31:0] ILLW  = 32'hFFFF_FFFF;

    // ---------------- stimulus ----------------
    initial begin
        int c;
        logic [31:0] e_jal, e_sw, e_ill;
        e_jal = eb(1,0,0,1,0,0,0,0,2'b10,4'b0000,3'b000);
        e_sw  = eb(0,1,0,0,0,1,0,0,2'b00,4'b0000,3'b000);
        e_ill = eb(0,0,0,0,0,0,0,1,2'b00,4'b0000,3'b000);

        // reset state
        drive(NOP, 1'b0, 1'b0, 1'b1, c);
        drive(NOP, 1'b0, 1'b0, 1'b1, c);
        push(c + 1, S_E,    32'd0, "rst_E");
        push(c + 1, S_M,    32'd0, "rst_M");
        push(c + 1, S_W,    32'd0, "rst_W");
        push(c + 1, S_CNT,  32'd0, "rst_CNT");
        push(c + 1, S_CNT0, 32'd0, "rst_CNT0");

        // lw through to W
        drive(LW, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_E,   eb(1,0,0,0,0,1,0,0,2'b01,4'b0000,3'b000), "lw_E");
        push(c + 1, S_IMM, 32'd0, "lw_IMM");
        push(c + 2, S_M,   32'b1001, "lw_M");
        push(c + 3, S_W,   32'b101, "lw_W");
        push(c + 3, S_W0,  32'b101, "lw_W0");

        // ALU decode patterns
        dec(SUB,   "sub",  eb(1,0,0,0,0,0,0,0,2'b00,4'b0001,3'b000), 3'b000);
        dec(SRAI,  "srai", eb(1,0,0,0,0,1,0,0,2'b00,4'b1000,3'b000), 3'b000);
        dec(SRLI,  "srli", eb(1,0,0,0,0,1,0,0,2'b00,4'b0111,3'b000), 3'b000);
        dec(XORI,  "xori", eb(1,0,0,0,0,1,0,0,2'b00,4'b0100,3'b000), 3'b000);
        dec(AND_R, "and",  eb(1,0,0,0,0,0,0,0,2'b00,4'b0010,3'b000), 3'b000);
        dec(OR_R,  "or",   eb(1,0,0,0,0,0,0,0,2'b00,4'b0011,3'b000), 3'b000);

        // lui: legal with extensions, illegal without
        drive(LUI, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_E,    eb(1,0,0,0,0,0,0,0,2'b11,4'b0000,3'b000), "lui_E");
        push(c + 1, S_IMM,  32'b100, "lui_IMM");
        push(c + 1, S_E0,   e_ill, "lui_E0");
        push(c + 1, S_IMM0, 32'd0, "lui_IMM0");
        push(c + 1, S_CNT0, 32'd1, "lui_CNT0");
        push(c + 1, S_CNT,  32'd0, "lui_CNT");

        // extended opcodes and branches
        dec(AUIPC, "auipc", eb(1,0,0,0,0,1,1,0,2'b00,4'b0000,3'b000), 3'b100);
        dec(JALR,  "jalr",  eb(1,0,0,1,1,1,0,0,2'b10,4'b0000,3'b000), 3'b000);
        dec(JAL,   "jal",   e_jal, 3'b011);
        dec(BEQ,   "beq",   eb(0,0,1,0,0,0,0,0,2'b00,4'b0001,3'b000), 3'b010);
        drive(BNE, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_E,  eb(0,0,1,0,0,0,0,0,2'b00,4'b0001,3'b001), "bne_E");
        push(c + 1, S_E0, e_ill, "bne_E0");
        dec(BLT,   "blt",   eb(0,0,1,0,0,0,0,0,2'b00,4'b0101,3'b100), 3'b010);
        dec(BGEU,  "bgeu",  eb(0,0,1,0,0,0,0,0,2'b00,4'b1001,3'b111), 3'b010);
        drive(BBAD, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_E,   e_ill, "bbad_E");
        push(c + 1, S_IMM, 32'd0, "bbad_IMM");
        push(c + 1, S_CNT, 32'd1, "bbad_CNT");

        // sw with a stall, then flush+stall
        drive(SW, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_E,   e_sw, "sw_E");
        push(c + 1, S_IMM, 32'b001, "sw_IMM");
        drive(SW, 1'b1, 1'b0, 1'b0, c);
        push(c + 1, S_E,   e_sw, "stall_E_hold");
        push(c + 1, S_M,   32'd0, "stall_M_bubble");
        drive(SW, 1'b1, 1'b1, 1'b0, c);
        push(c + 1, S_E,   32'd0, "flush_E");
        push(c + 1, S_M,   32'b0100, "flush_M_sw");
        drive(NOP, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_M,   32'd0, "after_flush_M");
        push(c + 1, S_E,   eb(1,0,0,0,0,1,0,0,2'b00,4'b0000,3'b000), "nop_E");

        // reset mid-stream, then resume
        drive(JAL, 1'b0, 1'b0, 1'b0, c);
        drive(BEQ, 1'b0, 1'b0, 1'b0, c);
        drive(JAL, 1'b0, 1'b0, 1'b1, c);
        push(c + 1, S_E,    32'd0, "midrst_E");
        push(c + 1, S_M,    32'd0, "midrst_M");
        push(c + 1, S_W,    32'd0, "midrst_W");
        push(c + 1, S_CNT,  32'd0, "midrst_CNT");
        push(c + 1, S_E0,   32'd0, "midrst_E0");
        push(c + 1, S_CNT0, 32'd0, "midrst_CNT0");
        drive(JAL, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_E, e_jal, "resume_E");
        push(c + 2, S_M, 32'b1010, "resume_M");
        push(c + 3, S_W, 32'b110, "resume_W");
        drive(NOP, 1'b0, 1'b0, 1'b0, c);

        // illegal while stalled or flushed is not counted
        drive(ILLW, 1'b1, 1'b0, 1'b0, c);
        push(c + 1, S_CNT, 32'd0, "ill_stall_CNT");
        drive(ILLW, 1'b1, 1'b1, 1'b0, c);
        push(c + 1, S_CNT, 32'd0, "ill_flush_CNT");
        push(c + 1, S_E,   32'd0, "ill_flush_E");

        // 260 illegal words: counter saturates at 255
        for (int k = 1; k <= 260; k++) begin
            drive(ILLW, 1'b0, 1'b0, 1'b0, c);
            if (k == 1) begin
                push(c + 1, S_E,   e_ill, "ill_E");
                push(c + 1, S_CNT, 32'd1, "sat_CNT_1");
            end
            if (k == 254) push(c + 1, S_CNT, 32'd254, "sat_CNT_254");
            if (k == 255) push(c + 1, S_CNT, 32'd255, "sat_CNT_255");
            if (k == 256) push(c + 1, S_CNT, 32'd255, "sat_CNT_256");
            if (k == 260) begin
                push(c + 1, S_CNT,  32'd255, "sat_CNT_260");
                push(c + 1, S_CNT0, 32'd255, "sat_CNT0_260");
            end
        end
        drive(NOP, 1'b0, 1'b0, 1'b0, c);
        push(c + 1, S_CNT, 32'd255, "sat_hold_CNT");

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_decoder.md
# ctrl_pipe_decoder

Parametrised successor to the main control decoder, placed in the decode stage of the 5-stage pipelined core. It combines main decode and ALU decode and optionally supports extended RV32I opcodes (lui, auipc, jalr, full branch set). It then carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers with stall/flush support. It also flags illegal opcodes and keeps a saturating illegal-instruction counter for debug.

## Interface
Parameters:
- EXT_EN, 1: 1 enables lui, auipc, jalr and bne/blt/bge/bltu/bgeu; 0 restricts to lw, sw, beq, R-type, I-type ALU, jal.
- ILL_CNT_W, 8: width of the illegal-instruction counter.

Ports:
- CLK  in  1  clock; everything is sampled on the rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- INSTR_D  in  32  instruction in decode.
- STALL_E  in  1  hold the ID/EX control register.
- FLUSH_E  in  1  load a bubble into ID/EX.
- IMMSRC_D  out  3  combinational immediate select: 000 I, 001 S, 010 B, 011 J, 100 U.
- REGWRITE_E, MEMWRITE_E, BRANCH_E, JUMP_E, JALR_E, ALUSRC_E, ALUSRCA_E, ILLEGAL_E  out  1 each  E-stage controls. ALUSRCA_E: 0 rs1, 1 PC.
- RESULTSRC_E  out  2  00 ALU, 01 mem, 10 PC+4, 11 immediate.
- ALUCTRL_E  out  4  ALU operation code.
- BRTYPE_E  out  3  funct3 of the branch.
- REGWRITE_M, MEMWRITE_M  out  1; RESULTSRC_M  out  2  M-stage controls.
- REGWRITE_W  out  1; RESULTSRC_W  out  2  W-stage controls.
- ILL_CNT  out  ILL_CNT_W  saturating count of illegal instructions accepted into E.

## Operation
- Decode is combinational from op = INSTR_D[6:0], funct3 = [14:12] and funct7b5 = [30].
- lw: IMM I, ALUSRC 1, RESULTSRC 01, REGWRITE 1, ALU add.
- sw: IMM S, ALUSRC 1, MEMWRITE 1, ALU add.
- R-type: REGWRITE 1, ALU from funct3/funct7b5.
- I-type ALU: IMM I, ALUSRC 1, REGWRITE 1, ALU from funct3. funct7b5 is used only for funct3 = 101 (srai).
- Branch: IMM B, BRANCH 1, BRTYPE = funct3. ALU op by funct3 class: 00x sub, 10x slt, 11x sltu.
  - With EXT_EN=0, only funct3 = 000 is legal.
  - funct3 = 010 or 011 is always illegal.
- jal: IMM J, JUMP 1, RESULTSRC 10, REGWRITE 1.
- jalr (EXT_EN): IMM I, ALUSRC 1, JUMP 1, JALR 1, RESULTSRC 10, REGWRITE 1, ALU add.
- lui (EXT_EN): IMM U, RESULTSRC 11, REGWRITE 1.
- auipc (EXT_EN): IMM U, ALUSRCA 1, ALUSRC 1, REGWRITE 1, ALU add.
- ALUCTRL codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu.
- Illegal instruction (unknown opcode, disabled opcode, or illegal funct3):
  - All control fields are 0 and IMMSRC_D = 000.
  - ILLEGAL asserts.
- ILL_CNT increments when an instruction with ILLEGAL=1 is loaded into E, i.e. not flushed and not stalled. It saturates at 2^ILL_CNT_W−1.

## Timing
- Decode to E: 1 cycle. E to M and M to W: 1 cycle each. Decode to W: 3 cycles.
- ID/EX register priority: RST > FLUSH_E > STALL_E > load.
  - Flush: all E fields become 0, including ILLEGAL_E.
  - Stall: E holds its value.
- M and W advance every cycle.
  - M loads the E bubble (zeros) whenever STALL_E=1 and FLUSH_E=0. This prevents a held instruction from retiring twice.
  - Otherwise M loads the current E fields.
- FLUSH_E and STALL_E asserted together: flush wins, and M loads the current E.
- RST: every registered output and ILL_CNT go to 0 on the next edge. This is also the required behaviour mid-operation; all in-flight controls are discarded.
- IMMSRC_D has no latency and does not depend on reset.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams;
  - ALUCTRL, IMMSRC and RESULTSRC codes;
  - a packed control-bundle struct (E fields), reused by the hazard unit.
- One sub-module: alu_ctrl_dec, a combinational mapping of (alu_op class, funct3, funct7b5, op[5]) to ALUCTRL.
- Pipeline registers stay in the top-level module.

## Test plan
- lw x5,4(x0) = 0x00402283 → next cycle: RESULTSRC_E=01, ALUSRC_E=1, REGWRITE_E=1, ALUCTRL_E=0000. Two cycles later: REGWRITE_W=1, RESULTSRC_W=01.
- sub x3,x1,x2 = 0x402081B3 → ALUCTRL_E=0001, ALUSRC_E=0. Then srai 0x4010D093 → ALUCTRL_E=1000.
- lui x1,0x12345 = 0x123450B7:
  - EXT_EN=1 → IMMSRC_D=100, RESULTSRC_E=11.
  - EXT_EN=0 → ILLEGAL_E=1, all controls 0, ILL_CNT goes 0→1.
- sw in D, with STALL_E=1 for one cycle, then FLUSH_E=1 together with STALL_E=1:
  - stall cycle → MEMWRITE_E holds 1 and MEMWRITE_M=0;
  - flush cycle → MEMWRITE_E=0, and M receives the held sw exactly once.
- Feed 260 illegal words 0xFFFFFFFF with ILL_CNT_W=8 → ILL_CNT saturates at 255.
- Stream jal/beq, assert RST for one cycle mid-stream → all _E, _M and _W outputs and ILL_CNT equal 0 after the edge. Decoding then resumes with the next instruction.
